// File: rtl/rom_image_loader.sv
// Byte-stream to 32-bit little-endian word writer for the instruction/data memory.
// Packs bytes into lanes, writes full or flushed partial words, and stops after the last word address.
module rom_image_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  flush,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] word_address,
  output logic [31:0]           wdata,
  output logic [3:0]            byte_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [2:0]            count, count_nxt;
  logic [31:0]           pack, pack_nxt;
  logic                  final_q, final_nxt;
  logic [3:0]            be_nxt;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    count_nxt = count;
    pack_nxt  = pack;
    final_nxt = final_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RECV;
          addr_nxt  = base_addr;
          count_nxt = 3'd0;
          pack_nxt  = '0;
          final_nxt = 1'b0;
        end
      end
      RECV: begin
        // byte_ready is high throughout RECV, so byte_valid alone marks acceptance
        if (byte_valid) begin
          pack_nxt[{count[1:0], 3'b000} +: 8] = byte_data;
          count_nxt = count + 3'd1;
        end
        // flush is evaluated against the count after this cycle's byte
        if (count_nxt == 3'd4) begin
          state_nxt = WRITE;
          final_nxt = flush;
        end else if (flush) begin
          final_nxt = 1'b1;
          state_nxt = (count_nxt == 3'd0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (final_q || addr == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RECV;
          addr_nxt  = addr + 1'b1;
          count_nxt = 3'd0;
          pack_nxt  = '0;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_nxt = 4'hF;
    case (count_nxt)
      3'd1: be_nxt = 4'h1;
      3'd2: be_nxt = 4'h3;
      3'd3: be_nxt = 4'h7;
      default: be_nxt = 4'hF;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      count        <= 3'd0;
      pack         <= '0;
      final_q      <= 1'b0;
      byte_ready   <= 1'b0;
      we           <= 1'b0;
      word_address <= '0;
      wdata        <= '0;
      byte_en      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      count      <= count_nxt;
      pack       <= pack_nxt;
      final_q    <= final_nxt;
      byte_ready <= (state_nxt == RECV);
      we         <= (state_nxt == WRITE);
      busy       <= (state_nxt == RECV) || (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
      if (state_nxt == WRITE) begin
        word_address <= addr_nxt;
        wdata        <= pack_nxt;
        byte_en      <= be_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rom_image_loader.sv
// Self-checking bench for rom_image_loader: directed scenarios plus randomized loads
// compared against a byte-list-to-word-list reference model.
module tb_rom_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        flush = 1'b0;
  logic        we;
  logic [7:0]  word_address;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t        wq[$];
  wr_t        exp_q[$];
  logic [7:0] bq[$];
  logic       ready_in_we = 1'b0;

  rom_image_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .flush(flush), .we(we), .word_address(word_address), .wdata(wdata),
    .byte_en(byte_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      wq.push_back('{a: word_address, d: wdata, be: byte_en});
      if (byte_ready) ready_in_we = 1'b1;
    end
  end

  // Reference: byte i lands in word base+i/4, lane i%4; words past 0xFF are never written.
  task automatic build_model(input int base);
    wr_t w;
    exp_q.delete();
    for (int n = 0; 4 * n < bq.size(); n++) begin
      if (base + n > 255) break;
      w.a = 8'(base + n);
      w.d = '0;
      w.be = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * n + k < bq.size()) begin
          w.d[8 * k +: 8] = bq[4 * n + k];
          w.be[k] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: byte_ready=%b required 1", byte_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl);
    int n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    flush = fl;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte 0x%02h never accepted", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    int n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom);
      base_addr = 8'($urandom);
      byte_valid = 1'($urandom);
      byte_data = 8'($urandom);
      flush = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if ({byte_ready, we, word_address, wdata, byte_en, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b we=%b addr=%h wdata=%h be=%h busy=%b done=%b required all 0",
               byte_ready, we, word_address, wdata, byte_en, busy, done);
    end
    rst = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    byte_valid = 1'b1;
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_accept: ready=%b busy=%b required 0 0", byte_ready, busy);
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL idle_no_write: writes=%0d required 0", wq.size());
    end
  endtask

  task automatic test_full_word();
    wq.delete();
    ready_in_we = 1'b0;
    do_start(8'h00);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    checks++;
    if (we !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_timing: we=%b ready=%b required 1 0", we, byte_ready);
    end
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL ready_return: ready=%b we=%b required 1 0", byte_ready, we);
    end
    send_byte(8'h99, 1'b1);
    wait_done();
    checks++;
    if (wq.size() != 2 || wq[0] !== {8'h00, 32'h44332211, 4'hF} || wq[1] !== {8'h01, 32'h00000099, 4'h1}) begin
      errors++;
      $display("FAIL full_word: writes=%0d w0=%h w1=%h required 2 0044332211f 0100000099 1",
               wq.size(), wq.size() > 0 ? wq[0] : '0, wq.size() > 1 ? wq[1] : '0);
    end
    checks++;
    if (ready_in_we !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_we: seen=%b required 0", ready_in_we);
    end
  endtask

  task automatic test_range_end();
    wq.delete();
    do_start(8'hFE);
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (we !== 1'b1 || word_address !== 8'hFF || wdata !== 32'h07060504) begin
      errors++;
      $display("FAIL last_write: we=%b addr=%h wdata=%h required 1 ff 07060504", we, word_address, wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_done: done=%b busy=%b required 1 0", done, busy);
    end
    byte_valid = 1'b1;
    byte_data = 8'h08;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || we !== 1'b0) begin
        errors++;
        $display("FAIL ninth_byte: ready=%b we=%b required 0 0", byte_ready, we);
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (wq.size() != 2 || wq[0] !== {8'hFE, 32'h03020100, 4'hF} || wq[1] !== {8'hFF, 32'h07060504, 4'hF}) begin
      errors++;
      $display("FAIL range_end: writes=%0d required 2 (03020100@fe, 07060504@ff)", wq.size());
    end
  endtask

  task automatic test_partial_flush();
    wq.delete();
    do_start(8'h40);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_flush();
    wait_done();
    checks++;
    if (wq.size() != 1 || wq[0] !== {8'h40, 32'h0000BBAA, 4'h3}) begin
      errors++;
      $display("FAIL partial_flush: writes=%0d w0=%h required 1 400000bbaa3", wq.size(), wq.size() > 0 ? wq[0] : '0);
    end
    wq.delete();
    do_start(8'h41);
    pulse_flush();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL empty_flush_done: done=%b required 1", done);
    end
    @(negedge clk);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL empty_flush: writes=%0d required 0", wq.size());
    end
  endtask

  task automatic test_simultaneous();
    wq.delete();
    do_start(8'h10);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 1 || wq[0] !== {8'h10, 32'h44332211, 4'hF}) begin
      errors++;
      $display("FAIL simultaneous: writes=%0d w0=%h required 1 1044332211f", wq.size(), wq.size() > 0 ? wq[0] : '0);
    end
  endtask

  task automatic test_mid_reset();
    wq.delete();
    do_start(8'h30);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0 || wq.size() != 0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ready=%b writes=%0d required 0 0 0", busy, byte_ready, wq.size());
    end
    do_start(8'h20);
    send_byte(8'h55, 1'b0);
    start = 1'b1;
    base_addr = 8'h80;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h56, 1'b0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h58, 1'b0);
    start = 1'b1;
    base_addr = 8'h90;
    @(negedge clk);
    start = 1'b0;
    pulse_flush();
    wait_done();
    checks++;
    if (wq.size() != 1 || wq[0] !== {8'h20, 32'h58575655, 4'hF}) begin
      errors++;
      $display("FAIL restart_no_stale: writes=%0d w0=%h required 1 2058575655f", wq.size(), wq.size() > 0 ? wq[0] : '0);
    end
  endtask

  task automatic test_random();
    int base, n, cap;
    logic fl_last;
    for (int it = 0; it < 12; it++) begin
      base = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(250, 255));
      n = $urandom_range(0, 12);
      cap = (256 - base) * 4;
      if (n > cap) n = cap;
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      fl_last = (n > 0 && n < cap) ? 1'($urandom) : 1'b0;
      build_model(base);
      wq.delete();
      do_start(8'(base));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(bq[i], (i == n - 1) ? fl_last : 1'b0);
      end
      if (n < cap && !fl_last) pulse_flush();
      wait_done();
      checks++;
      if (wq.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count: iter %0d base=%0h n=%0d writes=%0d required %0d", it, base, n, wq.size(), exp_q.size());
      end else begin
        for (int i = 0; i < wq.size(); i++) begin
          checks++;
          if (wq[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_write: iter %0d idx %0d got %h required %h", it, i, wq[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_range_end();
    test_partial_flush();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_image_loader.md
# rom_image_loader

Byte-stream writer that packs incoming bytes into 32-bit little-endian words and issues word writes to the instruction/data memory array. It fills memory in the layout the ROM read path exposes: byte address 4n+k maps to word n, bits [8k+7:8k]. It sits between a byte source (UART/testbench loader) and the memory write port. It also handles partial final words and address-range termination.

## Interface

- ADDR_WIDTH, 8, word-address width; the last word address is 2^ADDR_WIDTH-1.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; loads base_addr and begins a load. Honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address of the load.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming byte, in ascending byte-address order.
- byte_ready  out  1  loader accepts a byte this cycle.
- flush  in  1  end of stream; the pending partial word is written.
- we  out  1  memory write strobe, one cycle per word.
- word_address  out  ADDR_WIDTH  target word address while we=1.
- wdata  out  32  packed word; lanes not written are 0.
- byte_en  out  4  lane mask; bit k covers wdata[8k+7:8k].
- busy  out  1  high in RECV and WRITE.
- done  out  1  one-cycle completion pulse.

## Operation

- The FSM has four states: IDLE, RECV, WRITE and DONE. Reset state is IDLE.
- IDLE: byte_ready=0. When start=1, the loader loads base_addr into the address register, sets the lane count to 0, clears the packing register, and moves to RECV.
- RECV: byte_ready=1. A byte is accepted when byte_valid & byte_ready at a rising edge.
  - The accepted byte is stored in lane[count], and count is incremented.
  - On the 4th byte (count 3→4), the FSM moves to WRITE.
- Flush in RECV:
  - Flush is sampled after any byte accepted in the same cycle.
  - If the resulting count is 1–3, the FSM moves to WRITE and marks the write as final.
  - If the resulting count is 0, the FSM moves to DONE with no write.
  - If the resulting count is 4, the FSM moves to WRITE for a full word and marks it final.
- WRITE: lasts exactly one cycle.
  - Outputs are we=1, byte_en=(1<<count)-1 (4'hF when full), and wdata=packed register.
  - Next state is DONE if the write is final or word_address = 2^ADDR_WIDTH-1.
  - Otherwise word_address increments by 1, count and the packing register clear, and the FSM returns to RECV.
- DONE: done=1 and busy=0 for one cycle, then IDLE unconditionally. start is ignored in DONE.
- start in RECV or WRITE is ignored. flush outside RECV is ignored.
- Address arithmetic is ADDR_WIDTH bits. The address never wraps: the load terminates after writing the last word.
- Bytes offered while byte_ready=0 are not consumed. The source must hold them.

## Timing

- All outputs are registered. Reset values: byte_ready=0, we=0, word_address=0, wdata=0, byte_en=0, busy=0, done=0.
- The state is IDLE with count 0 after any rst cycle, including mid-word. Any partial word is discarded and no write is issued.
- start at edge T puts the FSM in RECV from cycle T+1, so byte_ready=1 in cycle T+1.
- When the 4th byte is accepted at edge T, we=1 in cycle T+1 and byte_ready=0 in that cycle. byte_ready returns to 1 in cycle T+2.
- Peak throughput is 4 bytes per 5 cycles.
- done asserts in the cycle after the final WRITE cycle, or the cycle after a flush with count 0.
- word_address, wdata and byte_en hold their values outside WRITE. Only we is qualified.

## Test plan

- Reset: hold rst 2 cycles with random inputs → all outputs 0, state IDLE, byte_ready=0. Then byte_valid=1 without start → no acceptance.
- Full word: start with base_addr=0x00, then back-to-back bytes 0x11,0x22,0x33,0x44 → exactly one we pulse. Required values: word_address=0x00, wdata=0x44332211, byte_en=4'hF, byte_ready=0 during the write, next word targets 0x01.
- Range end: base_addr=0xFE, 8 bytes 0x00..0x07 → writes 0x03020100@0xFE and 0x07060504@0xFF. done pulses in the next cycle. byte_ready=0 afterwards, and a 9th byte is not accepted.
- Partial flush: 0xAA,0xBB then flush → we with wdata=0x0000BBAA, byte_en=4'h3, then done. Flush with 0 pending bytes → done with no we.
- Simultaneous: 4th byte 0x44 accepted in the same cycle as flush, after 0x11,0x22,0x33 → single write of 0x44332211 with byte_en=4'hF, then done. There is no second write.
- Mid-operation: rst after 3 bytes → no we. A new start followed by bytes 0x55..0x58 → wdata=0x58575655, showing no stale lanes. Throughout, a start issued while busy has no effect.
